// File: rtl/alu_sweep_sequencer.sv
// alu_sweep_sequencer
// Runs an exhaustive self-check sweep over the operand-memory/ALU datapath.
// After an accepted start, it holds the memory initialise strobe high for
// INIT_CYCLES cycles. It then steps every ALU function code across every
// (address_a, address_b) pair. The loop order is b innermost, then a, then
// function outermost. Each operation is held for SETTLE+1 cycles. The
// result and flags are captured on the last edge of that window and folded
// into a rotating XOR signature and two flag counters.
//
// Handshake: start is a single-cycle request that is accepted only in IDLE
// when abort is low. busy is high from the accepted start until the sweep
// completes. done pulses for one cycle at completion. abort returns the
// block to IDLE on the next cycle from any active state, with no done pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          sweep request / cancel
//   alu_result/zr/ng      datapath response
//   initialise            memory preload strobe
//   address_a/address_b   operand addresses
//   zx, nx, zy, ny, f, no ALU control bits
//   busy, done            sweep status
//   signature             running result signature
//   zr_count, ng_count    number of captures with zr=1 / ng=1
module alu_sweep_sequencer #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int INIT_CYCLES = 2,
  parameter int SETTLE      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zr,
  input  logic                  alu_ng,
  output logic                  initialise,
  output logic [ADDR_W-1:0]     address_a,
  output logic [ADDR_W-1:0]     address_b,
  output logic                  zx,
  output logic                  nx,
  output logic                  zy,
  output logic                  ny,
  output logic                  f,
  output logic                  no,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     signature,
  output logic [2*ADDR_W+4:0]   zr_count,
  output logic [2*ADDR_W+4:0]   ng_count
);

  localparam int CNT_W  = 2*ADDR_W + 5;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST   = INIT_W'(INIT_CYCLES - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE);
  localparam logic [4:0]        LAST_FUNC   = 5'd17;
  localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t              state, state_d;
  logic [INIT_W-1:0]   init_cnt, init_cnt_d;
  logic [3:0]          settle_cnt, settle_cnt_d;
  logic [4:0]          func_idx, func_idx_d;
  logic [5:0]          ctrl, ctrl_d;
  logic [ADDR_W-1:0]   addr_a_d, addr_b_d;
  logic                initialise_d, busy_d, done_d;
  logic [DATA_W-1:0]   signature_d;
  logic [CNT_W-1:0]    zr_count_d, ng_count_d;

  // Function ROM: {zx,nx,zy,ny,f,no} for
  // 0, 1, -1, x, y, !x, !y, -x, -y, x+1, y+1, x-1, y-1, x+y, x-y, y-x, x&y, x|y
  function automatic logic [5:0] func_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    func_rom = 6'b101010;
      5'd1:    func_rom = 6'b111111;
      5'd2:    func_rom = 6'b111010;
      5'd3:    func_rom = 6'b001100;
      5'd4:    func_rom = 6'b110000;
      5'd5:    func_rom = 6'b001101;
      5'd6:    func_rom = 6'b110001;
      5'd7:    func_rom = 6'b001111;
      5'd8:    func_rom = 6'b110011;
      5'd9:    func_rom = 6'b011111;
      5'd10:   func_rom = 6'b110111;
      5'd11:   func_rom = 6'b001110;
      5'd12:   func_rom = 6'b110010;
      5'd13:   func_rom = 6'b000010;
      5'd14:   func_rom = 6'b010011;
      5'd15:   func_rom = 6'b000111;
      5'd16:   func_rom = 6'b000000;
      5'd17:   func_rom = 6'b010101;
      default: func_rom = 6'b000000;
    endcase
  endfunction

  always_comb begin
    state_d      = state;
    init_cnt_d   = init_cnt;
    settle_cnt_d = settle_cnt;
    func_idx_d   = func_idx;
    ctrl_d       = ctrl;
    addr_a_d     = address_a;
    addr_b_d     = address_b;
    initialise_d = initialise;
    busy_d       = busy;
    done_d       = 1'b0;
    signature_d  = signature;
    zr_count_d   = zr_count;
    ng_count_d   = ng_count;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_INIT;
          init_cnt_d   = '0;
          settle_cnt_d = '0;
          func_idx_d   = '0;
          ctrl_d       = '0;
          addr_a_d     = '0;
          addr_b_d     = '0;
          initialise_d = 1'b1;
          busy_d       = 1'b1;
          signature_d  = '0;
          zr_count_d   = '0;
          ng_count_d   = '0;
        end
      end

      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_d      = S_RUN;
          initialise_d = 1'b0;
          settle_cnt_d = '0;
          ctrl_d       = func_rom(func_idx);
        end else begin
          init_cnt_d = init_cnt + INIT_W'(1);
        end
      end

      S_RUN: begin
        if (settle_cnt == SETTLE_LAST) begin
          // Capture edge: fold the response in and advance to the next operation.
          signature_d  = {signature[DATA_W-2:0], signature[DATA_W-1]} ^ alu_result;
          zr_count_d   = zr_count + CNT_W'(alu_zr);
          ng_count_d   = ng_count + CNT_W'(alu_ng);
          settle_cnt_d = '0;
          addr_b_d     = address_b + ADDR_W'(1);
          if (address_b == ADDR_MAX) begin
            addr_a_d = address_a + ADDR_W'(1);
            if (address_a == ADDR_MAX) begin
              if (func_idx == LAST_FUNC) begin
                state_d    = S_DONE;
                func_idx_d = '0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
              end else begin
                func_idx_d = func_idx + 5'd1;
              end
            end
          end
          ctrl_d = (state_d == S_DONE) ? 6'b000000 : func_rom(func_idx_d);
        end else begin
          settle_cnt_d = settle_cnt + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides everything above. The captured results keep their partial values.
    if (abort && (state != S_IDLE)) begin
      state_d      = S_IDLE;
      init_cnt_d   = '0;
      settle_cnt_d = '0;
      func_idx_d   = '0;
      ctrl_d       = '0;
      addr_a_d     = '0;
      addr_b_d     = '0;
      initialise_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      signature_d  = signature;
      zr_count_d   = zr_count;
      ng_count_d   = ng_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      init_cnt   <= '0;
      settle_cnt <= '0;
      func_idx   <= '0;
      ctrl       <= '0;
      address_a  <= '0;
      address_b  <= '0;
      initialise <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= '0;
      zr_count   <= '0;
      ng_count   <= '0;
    end else begin
      state      <= state_d;
      init_cnt   <= init_cnt_d;
      settle_cnt <= settle_cnt_d;
      func_idx   <= func_idx_d;
      ctrl       <= ctrl_d;
      address_a  <= addr_a_d;
      address_b  <= addr_b_d;
      initialise <= initialise_d;
      busy       <= busy_d;
      done       <= done_d;
      signature  <= signature_d;
      zr_count   <= zr_count_d;
      ng_count   <= ng_count_d;
    end
  end

  assign {zx, nx, zy, ny, f, no} = ctrl;

endmodule

// File: tb/tb_alu_sweep_sequencer.sv
// Bench for alu_sweep_sequencer. Two instances share the clock and reset:
// u_dut1 (ADDR_W=1, SETTLE=1) and u_dut3 (ADDR_W=1, SETTLE=3).
// The operand memories and ALU are emulated behaviourally, and the
// expected results come from a mnemonic-level reference model.
module tb_alu_sweep_sequencer;
  localparam int AW  = 1;
  localparam int DW  = 16;
  localparam int CW  = 2*AW + 5;
  localparam int N   = 1 << AW;
  localparam int OPS = 18*N*N;
  localparam logic [5:0] CTRL_TAB [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (SETTLE=1) ----------------
  logic start1 = 1'b0, abort1 = 1'b0;
  logic [DW-1:0] res1, sig1, dp1;
  logic zr1, ng1, init1, zx1, nx1, zy1, ny1, f1, no1, busy1, done1;
  logic [AW-1:0] aa1, ab1;
  logic [CW-1:0] zrc1, ngc1;

  alu_sweep_sequencer #(.ADDR_W(AW), .DATA_W(DW), .INIT_CYCLES(2), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .alu_result(res1), .alu_zr(zr1), .alu_ng(ng1), .initialise(init1),
    .address_a(aa1), .address_b(ab1), .zx(zx1), .nx(nx1), .zy(zy1), .ny(ny1),
    .f(f1), .no(no1), .busy(busy1), .done(done1), .signature(sig1),
    .zr_count(zrc1), .ng_count(ngc1));

  // ---------------- DUT 3 (SETTLE=3) ----------------
  logic start3 = 1'b0, abort3 = 1'b0;
  logic [DW-1:0] res3, sig3, dp3;
  logic zr3, ng3, init3, zx3, nx3, zy3, ny3, f3, no3, busy3, done3, late3;
  logic [AW-1:0] aa3, ab3;
  logic [CW-1:0] zrc3, ngc3;

  alu_sweep_sequencer #(.ADDR_W(AW), .DATA_W(DW), .INIT_CYCLES(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .alu_result(res3), .alu_zr(zr3), .alu_ng(ng3), .initialise(init3),
    .address_a(aa3), .address_b(ab3), .zx(zx3), .nx(nx3), .zy(zy3), .ny(ny3),
    .f(f3), .no(no3), .busy(busy3), .done(done3), .signature(sig3),
    .zr_count(zrc3), .ng_count(ngc3));

  // ---------------- datapath emulation ----------------
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];

  function automatic logic [DW-1:0] hack(input logic [5:0] c, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] xx, yy, o;
    xx = c[5] ? '0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? '0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? xx + yy : xx & yy;
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    dp1  = hack({zx1, nx1, zy1, ny1, f1, no1}, mem_a[aa1], mem_b[ab1]);
    res1 = dp1;
    zr1  = (dp1 == '0);
    ng1  = dp1[DW-1];
    // DUT 3 sees a wrong response until the final settle cycle of each operation.
    dp3  = hack({zx3, nx3, zy3, ny3, f3, no3}, mem_a[aa3], mem_b[ab3]);
    res3 = late3 ? dp3 : ~dp3;
    zr3  = late3 ? (dp3 == '0) : (dp3 != '0);
    ng3  = late3 ? dp3[DW-1] : ~dp3[DW-1];
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_op(input int fn, input logic [DW-1:0] x, input logic [DW-1:0] y);
    case (fn)
      0:  return 16'd0;
      1:  return 16'd1;
      2:  return 16'hffff;
      3:  return x;
      4:  return y;
      5:  return ~x;
      6:  return ~y;
      7:  return 16'd0 - x;
      8:  return 16'd0 - y;
      9:  return x + 16'd1;
      10: return y + 16'd1;
      11: return x - 16'd1;
      12: return y - 16'd1;
      13: return x + y;
      14: return x - y;
      15: return y - x;
      16: return x & y;
      default: return x | y;
    endcase
  endfunction

  // Expected signature and counts after the first n operations of a sweep.
  task automatic model(input int n, output logic [DW-1:0] sig, output logic [CW-1:0] zc, output logic [CW-1:0] nc);
    int k;
    logic [DW-1:0] r;
    sig = '0; zc = '0; nc = '0; k = 0;
    for (int fn = 0; fn < 18; fn++)
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) begin
          if (k < n) begin
            r   = ref_op(fn, mem_a[a], mem_b[b]);
            sig = {sig[DW-2:0], sig[DW-1]} ^ r;
            zc  = zc + CW'(r == '0);
            nc  = nc + CW'(r[DW-1]);
          end
          k++;
        end
  endtask

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fails = 0;
  logic [7:0]         op_q [$];
  logic [DW+2*CW-1:0] res_q [$];
  logic [DW+2*CW-1:0] res3_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fails++;
    $display("FAIL %s", name);
  endtask

  // Monitor for DUT 1: operation order, hold time per operation, phase lengths and done results.
  logic [7:0] cur1, prev1;
  logic [DW+2*CW-1:0] got1;
  bit in_run1 = 0;
  int dur1 = 0, ops_seen1 = 0, run_cyc1 = 0, init_cyc1 = 0, done_seen1 = 0;

  always @(negedge clk) begin
    cur1 = {zx1, nx1, zy1, ny1, f1, no1, aa1, ab1};
    if (busy1 && !init1) begin
      if (!in_run1 || cur1 != prev1) begin
        if (in_run1) check("op_duration", 64'(dur1), 64'd2);
        if (op_q.size() == 0) fail_now("op_seq unexpected operation");
        else check("op_seq", 64'(cur1), 64'(op_q.pop_front()));
        ops_seen1++;
        dur1 = 1;
      end else begin
        dur1++;
      end
      in_run1 = 1;
      run_cyc1++;
    end else begin
      in_run1 = 0;
    end
    prev1 = cur1;
    if (init1) init_cyc1++;
    if (done1) begin
      done_seen1++;
      if (res_q.size() == 0) fail_now("done1 unexpected pulse");
      else begin
        got1 = res_q.pop_front();
        check("signature", 64'(sig1), 64'(got1[DW+2*CW-1:2*CW]));
        check("zr_count",  64'(zrc1), 64'(got1[2*CW-1:CW]));
        check("ng_count",  64'(ngc1), 64'(got1[CW-1:0]));
      end
    end
  end

  // Monitor for DUT 3: tracks the cycle within each operation and checks done results.
  logic [7:0] cur3, prev3;
  logic [DW+2*CW-1:0] got3;
  bit in_run3 = 0;
  int cyc3 = 0, run_cyc3 = 0, done_seen3 = 0;

  always_comb late3 = in_run3 && (cyc3 == 3);

  always @(negedge clk) begin
    cur3 = {zx3, nx3, zy3, ny3, f3, no3, aa3, ab3};
    if (busy3 && !init3) begin
      if (!in_run3 || cur3 != prev3) cyc3 = 0;
      else cyc3++;
      in_run3 = 1;
      run_cyc3++;
    end else begin
      in_run3 = 0;
      cyc3 = 0;
    end
    prev3 = cur3;
    if (done3) begin
      done_seen3++;
      if (res3_q.size() == 0) fail_now("done3 unexpected pulse");
      else begin
        got3 = res3_q.pop_front();
        check("s3_signature", 64'(sig3), 64'(got3[DW+2*CW-1:2*CW]));
        check("s3_zr_count",  64'(zrc3), 64'(got3[2*CW-1:CW]));
        check("s3_ng_count",  64'(ngc3), 64'(got3[CW-1:0]));
      end
    end
  end

  // ---------------- driver tasks (enter and leave at negedge + 1) ----------------
  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (rnd) begin
        mem_a[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        mem_b[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      end else begin
        mem_a[i] = 16'(i);
        mem_b[i] = 16'(i);
      end
    end
  endtask

  task automatic push_ops();
    for (int fn = 0; fn < 18; fn++)
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          op_q.push_back({CTRL_TAB[fn], AW'(a), AW'(b)});
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic check_ctrl_idle(input string name);
    check(name, 64'({busy1, done1, init1, zx1, nx1, zy1, ny1, f1, no1, aa1, ab1}), 64'd0);
  endtask

  task automatic wait_done1(input int bound);
    int k = 0;
    while (done_seen1 == 0 && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    if (done_seen1 == 0) begin
      fail_now("done1 timeout");
      op_q.delete();
      res_q.delete();
    end
  endtask

  task automatic run_sweep1(input bit rnd, input bit poke);
    logic [DW-1:0] s;
    logic [CW-1:0] z, n;
    fill_mem(rnd);
    model(OPS, s, z, n);
    res_q.push_back({s, z, n});
    push_ops();
    init_cyc1 = 0; run_cyc1 = 0; done_seen1 = 0;
    pulse_start1();
    check("cleared_on_start", 64'({sig1, zrc1, ngc1}), 64'd0);
    if (poke) begin
      @(negedge clk); #1;
      pulse_start1();                 // lands on the last INIT cycle
      repeat (20) @(negedge clk);
      #1;
      pulse_start1();                 // lands mid-RUN
    end
    wait_done1(600);
    repeat (3) @(negedge clk);
    #1;
    check("init_cycles", 64'(init_cyc1), 64'd2);
    check("run_cycles", 64'(run_cyc1), 64'(OPS*2));
    check("done_pulses", 64'(done_seen1), 64'd1);
    check("busy_after_done", 64'(busy1), 64'd0);
    check("ops_left", 64'(op_q.size()), 64'd0);
    op_q.delete();
  endtask

  task automatic do_abort(input int k, input bit rnd);
    logic [DW-1:0] s;
    logic [CW-1:0] z, n;
    int t;
    fill_mem(rnd);
    model(k, s, z, n);
    push_ops();
    ops_seen1 = 0; done_seen1 = 0;
    pulse_start1();
    t = 0;
    while (ops_seen1 < k + 1 && t < 600) begin
      @(negedge clk); #1;
      t++;
    end
    if (ops_seen1 < k + 1) fail_now("abort wait timeout");
    abort1 = 1'b1;
    @(negedge clk); #1;
    abort1 = 1'b0;
    check_ctrl_idle("abort_idle");
    check("abort_signature", 64'(sig1), 64'(s));
    check("abort_zr_count", 64'(zrc1), 64'(z));
    check("abort_ng_count", 64'(ngc1), 64'(n));
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_seen1), 64'd0);
    check("abort_hold", 64'({sig1, zrc1, ngc1}), 64'({s, z, n}));
    op_q.delete();
  endtask

  task automatic run_sweep3();
    logic [DW-1:0] s;
    logic [CW-1:0] z, n;
    int t;
    fill_mem(1'b1);
    model(OPS, s, z, n);
    res3_q.push_back({s, z, n});
    run_cyc3 = 0; done_seen3 = 0;
    start3 = 1'b1;
    @(negedge clk); #1;
    start3 = 1'b0;
    t = 0;
    while (done_seen3 == 0 && t < 1000) begin
      @(negedge clk); #1;
      t++;
    end
    if (done_seen3 == 0) begin
      fail_now("done3 timeout");
      res3_q.delete();
    end
    repeat (3) @(negedge clk);
    #1;
    check("s3_run_cycles", 64'(run_cyc3), 64'(OPS*4));
    check("s3_done_pulses", 64'(done_seen3), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_ctrl_idle("reset_ctrl");
    check("reset_results", 64'({sig1, zrc1, ngc1}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // start together with abort in IDLE is refused
    start1 = 1'b1;
    abort1 = 1'b1;
    @(negedge clk); #1;
    start1 = 1'b0;
    abort1 = 1'b0;
    @(negedge clk); #1;
    check_ctrl_idle("start_abort_idle");

    run_sweep1(1'b0, 1'b0);   // mem[0]=0, mem[1]=1
    run_sweep1(1'b1, 1'b1);   // random operands, stray start pulses
    do_abort(4, 1'b0);        // only constant-0 entries captured
    do_abort(10, 1'b1);
    run_sweep1(1'b1, 1'b0);   // restart after abort
    run_sweep3();
    run_sweep3();

    // asynchronous reset in the middle of RUN
    fill_mem(1'b1);
    push_ops();
    done_seen1 = 0;
    pulse_start1();
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_ctrl_idle("async_reset_ctrl");
    check("async_reset_results", 64'({sig1, zrc1, ngc1}), 64'd0);
    @(negedge clk); #1;
    op_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_no_done", 64'(done_seen1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
